fast_corner_engine: RTL and testbench

Parametrised FAST corner detector: reads Gaussian-filtered pixels from SRAM2, tests each pixel against its 16-pixel Bresenham ring (radius 3), and writes a saturated corner score per pixel to SRAM4 in raster order. Compared with the fixed FAST stage, it adds:
- runtime threshold;
- configurable arc length and pixel width;
- row-granular flow control against the Gaussian stage;
- a score output instead of a flag.

---
 rtl/fast_pkg.sv | 27 ++
 rtl/fast_corner_engine_if.sv | 25 ++
 rtl/fast_arc_eval.sv | 62 ++++++
 rtl/fast_corner_engine.sv | 152 +++++++++++++++
 tb/tb_fast_corner_engine.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast_pkg.sv
// Shared types for the FAST corner engine: FSM states and the radius-3 Bresenham ring offsets.
// Ring entry k is the k-th pixel clockwise, starting from the pixel directly above the center.
package fast_pkg;

  localparam int RING_N = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    FETCH,
    DRAIN,
    EVAL,
    WRITE,
    DONE
  } fast_state_t;

  localparam logic signed [2:0] RING_DX [RING_N] = '{
    3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
    3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
  };

  localparam logic signed [2:0] RING_DY [RING_N] = '{
    -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
     3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
  };

endpackage

// File: rtl/fast_corner_engine_if.sv
// SRAM2 read port and SRAM4 write port of the corner engine; read data returns one cycle after the request.
// The engine is the master: it issues reads and writes, the memories only supply read data.
interface fast_corner_engine_if #(
  parameter int PIX_W = 8,
  parameter int AW    = 7
);
  logic             read_SRAM2;
  logic [AW-1:0]    x_addr;
  logic [AW-1:0]    y_addr;
  logic [PIX_W-1:0] SRAM_in;
  logic             write_SRAM4;
  logic [AW-1:0]    x_addr4;
  logic [AW-1:0]    y_addr4;
  logic [PIX_W-1:0] score4;

  modport master (
    output read_SRAM2, x_addr, y_addr, write_SRAM4, x_addr4, y_addr4, score4,
    input  SRAM_in
  );

  modport slave (
    input  read_SRAM2, x_addr, y_addr, write_SRAM4, x_addr4, y_addr4, score4,
    output SRAM_in
  );
endinterface

// File: rtl/fast_arc_eval.sv
// Combinational FAST test: classifies the 16 ring pixels against center +/- threshold and scores the winning arc.
// No latency, no flow control; the score saturates at the all-ones pixel value.
module fast_arc_eval
  import fast_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9
) (
  input  logic [PIX_W-1:0]              center,
  input  logic [RING_N-1:0][PIX_W-1:0]  ring,
  input  logic [PIX_W-1:0]              threshold,
  output logic                          corner,
  output logic [PIX_W-1:0]              score
);

  localparam int SW = PIX_W + 5;

  // Circular run detection: the ring is closed, so a run may cross entry 15 -> 0.
  function automatic logic has_run(input logic [RING_N-1:0] m);
    logic found;
    logic run_ok;
    found = 1'b0;
    for (int s = 0; s < RING_N; s++) begin
      run_ok = 1'b1;
      for (int j = 0; j < ARC_LEN; j++) run_ok = run_ok & m[(s + j) % RING_N];
      found = found | run_ok;
    end
    return found;
  endfunction

  logic [RING_N-1:0] bright, dark, sel;
  logic              bright_run, dark_run;
  logic [PIX_W:0]    ext_c, ext_t, pk, d;
  logic [SW-1:0]     sum;

  always_comb begin
    bright     = '0;
    dark       = '0;
    pk         = '0;
    d          = '0;
    sum        = '0;
    ext_c      = {1'b0, center};
    ext_t      = {1'b0, threshold};
    for (int k = 0; k < RING_N; k++) begin
      pk        = {1'b0, ring[k]};
      bright[k] = pk > (ext_c + ext_t);
      dark[k]   = (pk + ext_t) < ext_c;
    end
    bright_run = has_run(bright);
    dark_run   = has_run(dark);
    corner     = bright_run | dark_run;
    sel        = bright_run ? bright : dark;
    for (int k = 0; k < RING_N; k++) begin
      pk = {1'b0, ring[k]};
      d  = bright_run ? (pk - ext_c - ext_t) : (ext_c - pk - ext_t);
      if (sel[k]) sum = sum + {{(SW-PIX_W-1){1'b0}}, d};
    end
    if (!corner) sum = '0;
    score = (|sum[SW-1:PIX_W]) ? '1 : sum[PIX_W-1:0];
  end

endmodule

// File: rtl/fast_corner_engine.sv
// Raster-order FAST scorer: 20 cycles per interior pixel (17 reads, drain, eval, write), 1 cycle per border pixel.
// Stalls in WAIT_ROW until the Gaussian stage has produced row y+3; new_trans aborts and restarts at (0,0).
module fast_corner_engine
  import fast_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int X_MAX   = 64,
  parameter int Y_MAX   = 64,
  parameter int ARC_LEN = 9,
  parameter int AW      = $clog2(X_MAX + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                new_trans,
  input  logic [AW-1:0]       max_x,
  input  logic [AW-1:0]       max_y,
  input  logic [PIX_W-1:0]    threshold,
  input  logic                gaus_sample_flag,
  input  logic                gaus_done,
  fast_corner_engine_if.master bus,
  output logic                busy,
  output logic                done
);

  fast_state_t state, state_nx;

  logic [AW-1:0]    mx, my, cx, cy, rows_avail, nx_x, nx_y, dx_ext, dy_ext;
  logic [PIX_W-1:0] thr, score_q, score;
  logic [4:0]       k, rd_idx_q;
  logic [3:0]       ri;
  logic             rd_vld_q, x_eol, last_pix, corner;
  logic [PIX_W-1:0] samp [RING_N+1];
  logic [RING_N-1:0][PIX_W-1:0] ring;

  // Widened compares keep x+4 from wrapping for images narrower than the ring.
  function automatic logic border_at(input logic [AW-1:0] x, y, w, h);
    return (x < AW'(3)) || (y < AW'(3)) ||
           (({1'b0, x} + (AW+1)'(4)) > {1'b0, w}) ||
           (({1'b0, y} + (AW+1)'(4)) > {1'b0, h});
  endfunction

  function automatic logic rows_ok_for(input logic [AW-1:0] y, input logic [AW-1:0] avail);
    return {1'b0, avail} >= ({1'b0, y} + (AW+1)'(4));
  endfunction

  assign x_eol    = (cx == mx - AW'(1));
  assign last_pix = x_eol && (cy == my - AW'(1));
  assign nx_x     = x_eol ? '0 : cx + AW'(1);
  assign nx_y     = x_eol ? cy + AW'(1) : cy;

  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (new_trans) begin
      state_nx = (max_x == '0 || max_y == '0) ? DONE : WRITE;
    end else begin
      case (state)
        IDLE:     state_nx = IDLE;
        WAIT_ROW: if (rows_ok_for(cy, rows_avail)) state_nx = FETCH;
        FETCH:    if (k == 5'd16) state_nx = DRAIN;
        DRAIN:    state_nx = EVAL;
        EVAL:     state_nx = WRITE;
        WRITE: begin
          if (last_pix)                            state_nx = DONE;
          else if (border_at(nx_x, nx_y, mx, my))  state_nx = WRITE;
          else if (rows_ok_for(nx_y, rows_avail))  state_nx = FETCH;
          else                                     state_nx = WAIT_ROW;
        end
        DONE:     state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mx         <= '0;
      my         <= '0;
      thr        <= '0;
      cx         <= '0;
      cy         <= '0;
      k          <= '0;
      rows_avail <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      score_q    <= '0;
      for (int i = 0; i < RING_N + 1; i++) samp[i] <= '0;
    end else if (new_trans) begin
      // A flag pulse coinciding with the restart is intentionally lost.
      mx         <= (max_x > AW'(X_MAX)) ? AW'(X_MAX) : max_x;
      my         <= (max_y > AW'(Y_MAX)) ? AW'(Y_MAX) : max_y;
      thr        <= threshold;
      cx         <= '0;
      cy         <= '0;
      k          <= '0;
      rows_avail <= '0;
      rd_vld_q   <= 1'b0;
      score_q    <= '0;
    end else begin
      if (gaus_done)
        rows_avail <= my;
      else if (gaus_sample_flag && rows_avail < my)
        rows_avail <= rows_avail + AW'(1);
      if (state == WRITE && !last_pix) begin
        cx <= nx_x;
        cy <= nx_y;
      end
      k        <= (state == FETCH) ? k + 5'd1 : 5'd0;
      rd_vld_q <= (state == FETCH);
      rd_idx_q <= k;
      if (rd_vld_q) samp[rd_idx_q] <= bus.SRAM_in;
      // Border writes rely on score_q having been cleared by the previous write.
      if (state == EVAL)       score_q <= corner ? score : '0;
      else if (state == WRITE) score_q <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < RING_N; i++) ring[i] = samp[i+1];
  end

  fast_arc_eval #(
    .PIX_W   (PIX_W),
    .ARC_LEN (ARC_LEN)
  ) u_arc_eval (
    .center    (samp[0]),
    .ring      (ring),
    .threshold (thr),
    .corner    (corner),
    .score     (score)
  );

  // Fetch slot k reads the center at k=0, ring entry k-1 afterwards.
  assign ri     = k[3:0] - 4'd1;
  assign dx_ext = {{(AW-3){RING_DX[ri][2]}}, RING_DX[ri]};
  assign dy_ext = {{(AW-3){RING_DY[ri][2]}}, RING_DY[ri]};

  assign bus.read_SRAM2  = (state == FETCH);
  assign bus.x_addr      = (k == 5'd0) ? cx : cx + dx_ext;
  assign bus.y_addr      = (k == 5'd0) ? cy : cy + dy_ext;
  assign bus.write_SRAM4 = (state == WRITE);
  assign bus.x_addr4     = cx;
  assign bus.y_addr4     = cy;
  assign bus.score4      = score_q;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_fast_corner_engine.sv
// Directed bench: two engines (arc 9 and arc 12) share stimulus and read the same image through SRAM models.
module tb_fast_corner_engine;

  localparam int AW = 7;

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [7:0]    s;
  } wr_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          new_trans = 1'b0;
  logic [AW-1:0] max_x = '0;
  logic [AW-1:0] max_y = '0;
  logic [7:0]    threshold = '0;
  logic          gaus_sample_flag = 1'b0;
  logic          gaus_done = 1'b0;
  logic          busy9, done9, busy12, done12;

  fast_corner_engine_if #(.PIX_W(8), .AW(AW)) bus9 ();
  fast_corner_engine_if #(.PIX_W(8), .AW(AW)) bus12 ();

  fast_corner_engine #(.PIX_W(8), .X_MAX(64), .Y_MAX(64), .ARC_LEN(9)) dut9 (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .gaus_sample_flag(gaus_sample_flag), .gaus_done(gaus_done),
    .bus(bus9), .busy(busy9), .done(done9)
  );

  fast_corner_engine #(.PIX_W(8), .X_MAX(64), .Y_MAX(64), .ARC_LEN(12)) dut12 (
    .clk(clk), .n_rst(n_rst), .new_trans(new_trans), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .gaus_sample_flag(gaus_sample_flag), .gaus_done(gaus_done),
    .bus(bus12), .busy(busy12), .done(done12)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:63][0:63];
  int rdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int rdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  always @(posedge clk) if (bus9.read_SRAM2)  bus9.SRAM_in  <= img[bus9.y_addr][bus9.x_addr];
  always @(posedge clk) if (bus12.read_SRAM2) bus12.SRAM_in <= img[bus12.y_addr][bus12.x_addr];

  // Monitor state: written only here, read by the stimulus block against saved bases.
  wr_t           wq [$];
  logic [13:0]   rdq [$];
  int            rd_cyc [$];
  int            cyc = 0, rd_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  int            n33 = 0, wr33_cyc = 0, n33_12 = 0, wr12_cnt = 0, done12_cnt = 0;
  logic [7:0]    s33 = '0, s33_12 = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus9.read_SRAM2) begin
      rd_cnt++;
      rdq.push_back({bus9.x_addr, bus9.y_addr});
      rd_cyc.push_back(cyc);
    end
    if (bus9.write_SRAM4) begin
      wq.push_back('{x: bus9.x_addr4, y: bus9.y_addr4, s: bus9.score4});
      if (bus9.x_addr4 == 3 && bus9.y_addr4 == 3) begin
        s33 = bus9.score4;
        n33++;
        wr33_cyc = cyc;
      end
    end
    if (bus9.read_SRAM2 && bus9.write_SRAM4) ovl_cnt++;
    if (done9) done_cnt++;
    if (bus12.write_SRAM4) begin
      wr12_cnt++;
      if (bus12.x_addr4 == 3 && bus12.y_addr4 == 3) begin
        s33_12 = bus12.score4;
        n33_12++;
      end
    end
    if (done12) done12_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  int wb, rb, db, rqb, n33b, n12b, w12b, d12b;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++) img[y][x] = v;
  endtask

  task automatic set_ring(input int k, input logic [7:0] v);
    img[3 + rdy[k]][3 + rdx[k]] = v;
  endtask

  task automatic start(input int w, input int h, input int t);
    @(negedge clk);
    wb = wq.size(); rb = rd_cnt; db = done_cnt; rqb = rdq.size();
    n33b = n33; n12b = n33_12; w12b = wr12_cnt; d12b = done12_cnt;
    max_x = AW'(w); max_y = AW'(h); threshold = 8'(t);
    new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == db && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    repeat (3) @(negedge clk);
    check_eq({tag, "_done"}, done_cnt - db, 1);
  endtask

  task automatic check_raster(input int w, input int h, input string tag);
    int bad, nz;
    bad = 0; nz = 0;
    check_eq({tag, "_nwr"}, wq.size() - wb, w * h);
    for (int i = 0; i < w * h && wb + i < wq.size(); i++) begin
      if (int'(wq[wb+i].x) != i % w || int'(wq[wb+i].y) != i / w) bad++;
      if (wq[wb+i].s != 0 && !(wq[wb+i].x == 3 && wq[wb+i].y == 3)) nz++;
    end
    check_eq({tag, "_order"}, bad, 0);
    check_eq({tag, "_border0"}, nz, 0);
  endtask

  task automatic check_ring_reads(input string tag);
    int bad, ex, ey;
    bad = 0;
    if (rdq.size() - rqb != 17) bad = 99;
    else begin
      for (int k = 0; k < 17; k++) begin
        ex = (k == 0) ? 3 : 3 + rdx[k-1];
        ey = (k == 0) ? 3 : 3 + rdy[k-1];
        if (rdq[rqb+k] != {AW'(ex), AW'(ey)}) bad++;
      end
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wab;
    fill(8'd100);

    // Reset
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy9, 0);
    check_eq("rst_done", done9, 0);
    check_eq("rst_rd", bus9.read_SRAM2, 0);
    check_eq("rst_wr", bus9.write_SRAM4, 0);
    check_eq("rst_score", bus9.score4, 0);
    check_eq("rst_xaddr4", bus9.x_addr4, 0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("idle_rd", rd_cnt, 0);
    check_eq("idle_wr", wq.size(), 0);
    check_eq("idle_busy", busy9, 0);

    // Flat 7x7
    gaus_done = 1'b1;
    start(7, 7, 20);
    check_eq("busy_after_start", busy9, 1);
    wait_done(300, "flat");
    check_raster(7, 7, "flat");
    check_eq("flat_reads", rd_cnt - rb, 17);
    check_eq("flat_s33", s33, 0);
    check_eq("flat_busy_end", busy9, 0);
    check_eq("flat_ovl", ovl_cnt, 0);
    check_eq("flat_arc12_nwr", wr12_cnt - w12b, 49);
    check_ring_reads("flat_addr");

    // Dark arc k=0..8, score saturates
    fill(8'd200);
    for (int k = 0; k <= 8; k++) set_ring(k, 8'd100);
    start(7, 7, 20);
    wait_done(300, "arc");
    check_raster(7, 7, "arc");
    check_eq("arc_s33", s33, 255);
    check_eq("arc12_s33", s33_12, 0);
    check_eq("arc_lat", (rd_cyc.size() > rqb) ? wr33_cyc - rd_cyc[rqb] : -1, 19);

    // Wrap-around dark run 12..15,0..4
    fill(8'd200);
    for (int k = 12; k <= 15; k++) set_ring(k, 8'd170);
    for (int k = 0; k <= 4; k++) set_ring(k, 8'd170);
    start(7, 7, 20);
    wait_done(300, "wrap");
    check_eq("wrap_s33", s33, 90);
    check_eq("wrap12_s33", s33_12, 0);
    check_eq("wrap_n33", n33 - n33b, 1);

    // Row flow control
    fill(8'd100);
    gaus_done = 1'b0;
    start(7, 7, 20);
    repeat (6) begin
      @(negedge clk) gaus_sample_flag = 1'b1;
      @(negedge clk) gaus_sample_flag = 1'b0;
    end
    repeat (40) @(negedge clk);
    check_eq("flow_nwr", wq.size() - wb, 24);
    check_eq("flow_rd", rd_cnt - rb, 0);
    check_eq("flow_busy", busy9, 1);
    @(negedge clk) gaus_sample_flag = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      gaus_sample_flag = 1'b0;
      lat++;
    end while (!bus9.read_SRAM2 && lat < 10);
    check_eq("flow_lat_le2", int'(lat <= 2), 1);
    gaus_done = 1'b1;
    wait_done(300, "flow");
    check_eq("flow_total", wq.size() - wb, 49);

    // Abort during FETCH of (3,3)
    start(7, 7, 20);
    lat = 0;
    while (rd_cnt == rb && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    repeat (5) @(negedge clk);
    check_eq("rs_pre_nwr", wq.size() - wb, 24);
    wab = wq.size();
    new_trans = 1'b1;
    @(negedge clk);
    new_trans = 1'b0;
    wait_done(300, "rs");
    check_eq("rs_total", wq.size() - wb, 73);
    check_eq("rs_first_xy", (wq.size() > wab) ? int'({wq[wab].x, wq[wab].y}) : -1, 0);
    check_eq("rs_n33", n33 - n33b, 1);

    // Zero dimension and small image
    start(0, 5, 20);
    wait_done(20, "zero");
    check_eq("zero_nwr", wq.size() - wb, 0);
    start(5, 4, 20);
    wait_done(100, "small");
    check_raster(5, 4, "small");
    check_eq("small_rd", rd_cnt - rb, 0);
    check_eq("small_arc12_done", done12_cnt - d12b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
